// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch -- multi-channel PWM generator with a shared period counter.
//
// CHANNELS outputs share one counter. Each channel compares the counter with its
// own duty value. The counter runs edge-aligned (0..P, then 0) or center-aligned
// (0..P..1, then 0). Period, duties and mode are double-buffered: a load strobe
// writes shadow registers, which are copied to the active set only at a period
// boundary, or at once while the block is disabled.
//
// Optional build macro: PWM_INVERT_EN adds a per-channel 'polarity' input that
// XORs each compare result and sets the idle level while disabled.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   enable       1 = counter runs; 0 = counter held at 0, outputs idle
//   load         one-cycle strobe: capture period_new/duty_new/mode_new to shadow
//   period_new   new period P (WIDTH bits)
//   duty_new     new duties, channel i at [i*WIDTH +: WIDTH]
//   mode_new     0 = edge-aligned, 1 = center-aligned
//   polarity     (PWM_INVERT_EN only) per-channel output inversion / idle level
//   pwm_out      registered PWM outputs
//   period_end   registered one-cycle pulse in the cycle after each terminal cycle
//   load_pending shadow registers hold values not yet applied
module pwm_multi_ch #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_new,
    input  logic [CHANNELS*WIDTH-1:0] duty_new,
    input  logic                      mode_new,
`ifdef PWM_INVERT_EN
    input  logic [CHANNELS-1:0]       polarity,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      load_pending
);

    // Counter direction; only meaningful in center mode.
    localparam logic DirUp   = 1'b0;
    localparam logic DirDown = 1'b1;

    // Active (in-use) configuration.
    logic [WIDTH-1:0]          period_q, period_d;
    logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
    logic                      mode_q, mode_d;

    // Shadow configuration written by load.
    logic [WIDTH-1:0]          sh_period_q, sh_period_d;
    logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic                      sh_mode_q, sh_mode_d;
    logic                      load_pending_q, load_pending_d;

    // Counter state and registered outputs.
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      dir_q, dir_d;
    logic [CHANNELS-1:0]       pwm_out_q, pwm_out_d;
    logic                      period_end_q, period_end_d;

    // Free-running next counter value, ignoring enable and apply.
    logic [WIDTH-1:0]          cnt_next;
    logic                      dir_next;
    logic                      terminal;
    logic                      apply;
    logic [CHANNELS-1:0]       pol;

`ifdef PWM_INVERT_EN
    assign pol = polarity;
`else
    assign pol = '0;
`endif

    // Counter sequencing. cnt never exceeds period_q, so no wrap is possible.
    always_comb begin
        cnt_next = '0;
        dir_next = DirUp;
        if (period_q == '0) begin
            // P=0: counter pinned at 0, every cycle terminal.
            cnt_next = '0;
            dir_next = DirUp;
        end else if (!mode_q) begin
            cnt_next = (cnt_q >= period_q) ? '0 : cnt_q + 1'b1;
            dir_next = DirUp;
        end else if (dir_q == DirUp) begin
            if (cnt_q >= period_q) begin
                // Turn around at the top. For P=1 this lands straight on 0,
                // which ends the period, so the direction stays up.
                cnt_next = period_q - 1'b1;
                dir_next = (period_q == {{(WIDTH-1){1'b0}}, 1'b1}) ? DirUp : DirDown;
            end else begin
                cnt_next = cnt_q + 1'b1;
                dir_next = DirUp;
            end
        end else begin
            if (cnt_q <= {{(WIDTH-1){1'b0}}, 1'b1}) begin
                cnt_next = '0;
                dir_next = DirUp;
            end else begin
                cnt_next = cnt_q - 1'b1;
                dir_next = DirDown;
            end
        end
    end

    assign terminal = (cnt_next == '0);

    // Next-state for configuration, counter and outputs.
    always_comb begin
        period_d       = period_q;
        duty_d         = duty_q;
        mode_d         = mode_q;
        sh_period_d    = sh_period_q;
        sh_duty_d      = sh_duty_q;
        sh_mode_d      = sh_mode_q;
        load_pending_d = load_pending_q;
        cnt_d          = cnt_q;
        dir_d          = dir_q;
        pwm_out_d      = pol;
        period_end_d   = 1'b0;
        apply          = 1'b0;

        if (enable) begin
            cnt_d        = cnt_next;
            dir_d        = dir_next;
            period_end_d = terminal;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pwm_out_d[i] = (cnt_q < duty_q[i*WIDTH +: WIDTH]) ^ pol[i];
            end
            apply = terminal & load_pending_q;
        end else begin
            // Held idle: nothing is mid-pulse, so pending values apply at once.
            cnt_d = '0;
            dir_d = DirUp;
            apply = load_pending_q;
        end

        if (apply) begin
            period_d       = sh_period_q;
            duty_d         = sh_duty_q;
            mode_d         = sh_mode_q;
            cnt_d          = '0;
            dir_d          = DirUp;
            load_pending_d = 1'b0;
        end

        // A load coinciding with an apply lands in the shadow set only; the
        // apply above used the previous shadow contents.
        if (load) begin
            sh_period_d    = period_new;
            sh_duty_d      = duty_new;
            sh_mode_d      = mode_new;
            load_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q       <= '1;
            duty_q         <= '0;
            mode_q         <= 1'b0;
            sh_period_q    <= '0;
            sh_duty_q      <= '0;
            sh_mode_q      <= 1'b0;
            load_pending_q <= 1'b0;
            cnt_q          <= '0;
            dir_q          <= DirUp;
            pwm_out_q      <= '0;
            period_end_q   <= 1'b0;
        end else begin
            period_q       <= period_d;
            duty_q         <= duty_d;
            mode_q         <= mode_d;
            sh_period_q    <= sh_period_d;
            sh_duty_q      <= sh_duty_d;
            sh_mode_q      <= sh_mode_d;
            load_pending_q <= load_pending_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            pwm_out_q      <= pwm_out_d;
            period_end_q   <= period_end_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_end   = period_end_q;
    assign load_pending = load_pending_q;

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Multi-channel, parametrised successor to the single-channel dynamic PWM controller. CHANNELS outputs share one period counter, each with its own duty value. The block supports edge-aligned and center-aligned counting. Period, duties and mode are double-buffered: a load strobe writes them to shadow registers, and they take effect only at a period boundary, so no output ever produces a glitched or truncated pulse.

Parameters:
WIDTH, 8, bit width of the counter, period and each duty value
CHANNELS, 4, number of PWM outputs (1..16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = counter runs; 0 = counter held, outputs low
load  input  1  single-cycle strobe; captures period_new, duty_new and mode_new into the shadow registers
period_new  input  WIDTH  new period value P
duty_new  input  CHANNELS*WIDTH  new duty values; channel i is in bits [i*WIDTH +: WIDTH]
mode_new  input  1  0 = edge-aligned, 1 = center-aligned
pwm_out  output  CHANNELS  registered PWM outputs
period_end  output  1  registered one-cycle pulse, one cycle after each terminal cycle
load_pending  output  1  shadow registers hold values not yet applied

Behaviour:
- Reset values:
  - cnt=0, dir=up, active period = all ones, active duties = 0, active mode = edge.
  - Shadow registers = 0; pwm_out=0, period_end=0, load_pending=0.
- Counter, edge mode: counts 0,1,…,P, then 0. Period length is P+1 cycles.
- Counter, center mode: counts 0,1,…,P, then P-1,…,1, then 0. Period length is 2P cycles. For P=1 the sequence is 0,1,0,1.
- P=0, either mode: cnt stays at 0 and every cycle is a terminal cycle.
- Terminal cycle: the cycle whose next cnt value is 0.
- Compare: pwm_out[i] is registered as (cnt < duty_active[i]), so the output lags cnt by one cycle.
  - Edge mode: high for min(D, P+1) cycles per period.
  - Center mode: high for 2D-1 cycles when 1≤D≤P, always high when D>P.
  - D=0 gives an output that is always low, in both modes.
- Comparisons are unsigned WIDTH-bit. There is no arithmetic overflow: cnt never exceeds P.
- Load:
  - load=1 copies all inputs into the shadow registers and sets load_pending.
  - A later load before the boundary overwrites the shadow registers (last write wins).
- Apply: in a terminal cycle with load_pending=1, shadow values are copied to the active registers and load_pending clears.
  - The next cycle starts with cnt=0, dir=up and the new period, duties and mode.
  - A mode switch takes effect only at this point.
- Load in a terminal cycle: the strobed values go to the shadow registers only and are applied at the next terminal cycle; load_pending stays 1.
- period_end: pulses high for one cycle on the cycle after each terminal cycle. It is not asserted while enable=0.
- enable=0:
  - cnt is held at 0 with dir=up, and pwm_out is driven to 0 on the next clock.
  - Pending shadow values are applied immediately, so load_pending clears the cycle after load.
  - On enable rising, counting starts from 0 with the latest values.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronous). Counting resumes on the first clock after deassertion.

Optional Feature:
Macro PWM_INVERT_EN.
- Defined: adds input port polarity [CHANNELS-1:0], sampled every cycle. pwm_out[i] = compare result XOR polarity[i], registered. With enable=0, output i is driven to polarity[i] (its idle level). The reset value of pwm_out stays 0.
- Undefined: the port is absent and outputs are active-high exactly as described above.

Test Plan:
- Edge mode, P=9, duty0=3, duty1=0, duty2=10, duty3=9, enable=1:
  - pwm_out[0] is high 3 cycles / low 7 cycles.
  - pwm_out[1] is always 0.
  - pwm_out[2] is always 1.
  - pwm_out[3] is high 9 of 10 cycles.
  - period_end pulses every 10 cycles.
- Center mode, P=4, duty0=2: cnt follows 0,1,2,3,4,3,2,1. pwm_out[0] is high 3 of 8 cycles, and period_end pulses every 8 cycles.
- Mid-period reload: edge mode with P=127, D=32; at cnt=50, load P=63, D=48.
  - load_pending=1 until the boundary.
  - The old period finishes at 128 cycles with 32 high.
  - After that, periods are 64 cycles with 48 high.
  - load_pending clears at the boundary.
- Double load and boundary collision:
  - Two loads before the boundary: only the second set of values is applied.
  - A load exactly in a terminal cycle is applied one period later.
- Disable and reset: enable=0 mid-period, then load P=15.
  - cnt=0, pwm_out=0 next cycle, and load_pending clears in 1 cycle.
  - After enable=1, the period is 16 cycles.
  - An async rst pulse mid-count clears all outputs without waiting for a clock edge.
- P=0 and P=1 corner cases, plus the PWM_INVERT_EN build:
  - P=0 gives a constant output and period_end high every enabled cycle.
  - P=1 in center mode gives a 2-cycle period.
  - With PWM_INVERT_EN, polarity=4'b0101 inverts channels 0 and 2, and the idle level while disabled equals polarity.
